// File: rtl/arith_pkg.sv
// ============================================================================
// Module   : arith_pkg
// Brief    : Shared types and constants for the bit-serial arithmetic engines.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Brief    : 1-bit full-subtractor cell, counterpart of the full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : LSB-first bit-serial A - B with borrow-out and signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int                 c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bw;
    logic               r_ov;

    logic               w_load;
    logic               w_run;
    logic               w_last;
    logic               w_fin;
    logic               w_d;
    logic               w_bout;

    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bw),
        .d    (w_d),
        .bout (w_bout)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        busy   = 1'b0;
        w_load = 1'b0;
        w_run  = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            IDLE: w_load = start;
            RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
            end
            DONE: begin
                busy  = 1'b1;
                w_fin = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign w_last = w_run && (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // Datapath: operand/result shifters, borrow FF, counter, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_bw     <= 1'b0;
            r_ov     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_load) begin
                r_a   <= a;
                r_b   <= b;
                r_bw  <= 1'b0;
                r_cnt <= '0;
            end
            if (w_run) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= {w_d, r_res[WIDTH-1:1]};
                r_bw  <= w_bout;
                r_cnt <= r_cnt + c_ONE;
                // Signed overflow: borrow into the MSB differs from borrow out.
                if (w_last) begin
                    r_ov <= r_bw ^ w_bout;
                end
            end
            if (w_fin) begin
                diff     <= r_res;
                borrow   <= r_bw;
                overflow <= r_ov;
                done     <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen (at least one edge), bounded by 'bound' edges.
    task automatic wait_done(input int bound, output int k, output int nbusy, output bit moved);
        logic [W-1:0] d0;
        d0    = diff;
        k     = 0;
        nbusy = 0;
        moved = 1'b0;
        do begin
            if (busy) nbusy++;
            tick();
            k++;
            if (!done && diff !== d0) moved = 1'b1;
        end while (!done && k < bound);
    endtask

    task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ed, input logic eb, input logic eo);
        int k, nb;
        bit mv;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~av; b = ~bv;
        wait_done(20, k, nb, mv);
        chk({tag, " latency"},     k,        9);
        chk({tag, " busy_cycles"}, nb,       9);
        chk({tag, " diff_stable"}, mv,       0);
        chk({tag, " diff"},        diff,     ed);
        chk({tag, " borrow"},      borrow,   eb);
        chk({tag, " overflow"},    overflow, eo);
        chk({tag, " busy_after"},  busy,     0);
        tick();
        chk({tag, " done_single"}, done,     0);
    endtask

    initial begin
        int k, nb, nd;
        bit mv;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst busy",     busy,     0);
        chk("rst done",     done,     0);
        chk("rst diff",     diff,     0);
        chk("rst borrow",   borrow,   0);
        chk("rst overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        op("05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // start pulse during RUN must be ignored
        a = 8'h10; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, k, nb, mv);
        chk("ign latency",  k,        6);
        chk("ign diff",     diff,     8'h0F);
        chk("ign borrow",   borrow,   0);
        chk("ign overflow", overflow, 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) nd++;
        end
        chk("ign no_second_done", nd,   0);
        chk("ign idle",           busy, 0);

        op("03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // reset in the middle of an operation
        a = 8'hFF; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst busy",     busy,     0);
        chk("mid_rst done",     done,     0);
        chk("mid_rst diff",     diff,     0);
        chk("mid_rst borrow",   borrow,   0);
        chk("mid_rst overflow", overflow, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) nd++;
        end
        chk("mid_rst no_done", nd, 0);

        op("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // start held high: back-to-back operations every WIDTH+2 cycles
        a = 8'h20; b = 8'h10; start = 1'b1;
        wait_done(30, k, nb, mv);
        chk("held first latency", k,    10);
        chk("held first diff",    diff, 8'h10);
        for (int p = 0; p < 3; p++) begin
            wait_done(30, k, nb, mv);
            chk("held period",      k,        10);
            chk("held diff_stable", mv,       0);
            chk("held diff",        diff,     8'h10);
            chk("held borrow",      borrow,   0);
            chk("held overflow",    overflow, 0);
        end
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor; the inverse arithmetic of the team's 1-bit full-adder cell.
- Accepts two WIDTH-bit operands on a start pulse and computes A − B LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Returns the difference, borrow-out and signed overflow, with a one-cycle done pulse.
- Sits behind the pin-level wrapper as a small arithmetic engine for the next tapeout tile.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only in IDLE.
- a  in  WIDTH  minuend; sampled on the accepted start cycle.
- b  in  WIDTH  subtrahend; sampled on the accepted start cycle.
- busy  out  1  high in RUN and DONE.
- done  out  1  single-cycle pulse when results are valid.
- diff  out  WIDTH  A − B mod 2^WIDTH.
- borrow  out  1  unsigned borrow-out (1 iff a < b unsigned).
- overflow  out  1  signed overflow of A − B.

Behaviour:
- Reset (rst_n=0 at a clock edge): FSM → IDLE. busy, done, diff, borrow, overflow, internal shift registers, bit counter and borrow FF all → 0.
- FSM states:
  - IDLE → RUN on start=1. Load a, b into shift registers; clear borrow FF and counter.
  - RUN: one bit per cycle.
    - d = a0 ^ b0 ^ bw.
    - bw' = (~a0 & b0) | (~(a0 ^ b0) & bw).
    - Shift both operand registers right; shift d into the MSB of the internal result shift register.
    - Counter increments.
    - On the cycle processing bit WIDTH−1, capture ov = bw_in_msb ^ bw_out_msb.
    - RUN → DONE after exactly WIDTH cycles.
  - DONE (1 cycle): diff ← result register, borrow ← final bw', overflow ← ov, done=1. Then → IDLE.
- Latency: start accepted at edge 0; done high during the cycle after edge WIDTH+1 (9 cycles for WIDTH=8). Throughput: one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored; no effect on operands, counter or outputs.
- diff, borrow, overflow hold their last values from DONE until the next DONE. They do not change during RUN.
- a, b changing after acceptance: no effect.
- Reset mid-RUN: aborts immediately; no done pulse; outputs cleared as above.
- start held high continuously: a new operation begins on each IDLE cycle, i.e. back-to-back every WIDTH+2 cycles.
- Arithmetic is purely modular; no saturation.

Decomposition:
- Shared package (arith_pkg):
  - FSM state enum {IDLE, RUN, DONE}.
  - Default WIDTH constant.
  - Counter width = $clog2(WIDTH+1).
- Sub-module full_subtractor (combinational: a, b, bin → d, bout) is the natural cell, mirroring the team's adder cell. Instantiate it once.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, start 1 cycle → done pulse 9 cycles later; diff=0x02, borrow=0, overflow=0; busy high for exactly 9 cycles.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, borrow=0, overflow=1. a=0x7F, b=0xFF → diff=0x80, borrow=1, overflow=1.
- Run a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 at RUN cycle 3 → single done, diff=0x0F; no second done until a new start in IDLE.
- rst_n=0 for 1 cycle at RUN cycle 4 of a=0xFF, b=0x01 → no done pulse; all outputs 0 next cycle. A following start with a=0x00, b=0x00 → diff=0x00, borrow=0, overflow=0.
- start held high with constant a=0x20, b=0x10 → done every 10 cycles, diff=0x10 each time; outputs stable between pulses.
